// File: rtl/mux_pkg.sv
// Shared slot encoding and FSM state type for the 4:1 TDM mux/demux pair.
// Slot n carries channel n; {s2,s1} on the mux side uses the same encoding.
package mux_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_A = 2'd0;
  localparam slot_t SLOT_B = 2'd1;
  localparam slot_t SLOT_C = 2'd2;
  localparam slot_t SLOT_D = 2'd3;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Purpose: 2-bit TDM slot position with clear/load-1/advance controls and a wrap flag.
// Latency: slot updates on the edge after a control; o_wrap is combinational from the slot.
// Backpressure: none; controls are single-cycle strobes, clear beats load beats advance.
module tdm_slot_counter
  import mux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_clr,
  input  logic  i_load1,
  input  logic  i_adv,
  output slot_t o_slot,
  output logic  o_wrap
);

  slot_t r_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SLOT_A;
    end else if (i_clr) begin
      r_slot <= SLOT_A;
    end else if (i_load1) begin
      r_slot <= SLOT_B;
    end else if (i_adv) begin
      // Natural 2-bit overflow gives the 3 -> 0 wrap.
      r_slot <= r_slot + 2'd1;
    end
  end

  assign o_slot = r_slot;
  assign o_wrap = (r_slot == SLOT_D);

endmodule

// File: rtl/tdm_demux4.sv
// Purpose: rebuild four channels from a sync-marked TDM beat stream; TDM_DEMUX_ERR_CNT_EN adds err_count/err_clr.
// Latency: outputs and frame_valid update 1 cycle after the slot-3 beat; sync_err 1 cycle after the bad beat.
// Backpressure: none; every in_valid beat is consumed, idle cycles are ignored.
module tdm_demux4
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  output logic             sync_err,
`ifdef TDM_DEMUX_ERR_CNT_EN
  output logic [7:0]       err_count,
  input  logic             err_clr,
`endif
  output logic             locked
);

  demux_state_t     r_state;
  logic [WIDTH-1:0] r_sh_a, r_sh_b, r_sh_c;
  logic [WIDTH-1:0] r_out_a, r_out_b, r_out_c, r_out_d;
  logic             r_frame_valid;
  logic             r_sync_err;

  slot_t w_slot;
  logic  w_wrap;
  logic  w_lk;
  logic  w_load1;
  logic  w_early;
  logic  w_miss;
  logic  w_adv;
  logic  w_frame_done;

  assign w_lk = (r_state == LOCKED);

  // Any sync beat (HUNT or LOCKED) becomes slot 0; early ones also flag an error.
  assign w_load1      = in_valid & in_sync;
  assign w_early      = in_valid & in_sync & w_lk & (w_slot != SLOT_A);
  assign w_miss       = in_valid & ~in_sync & w_lk & (w_slot == SLOT_A);
  assign w_adv        = in_valid & ~in_sync & w_lk & (w_slot != SLOT_A);
  assign w_frame_done = w_adv & w_wrap;

  tdm_slot_counter u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_miss),
    .i_load1 (w_load1),
    .i_adv   (w_adv),
    .o_slot  (w_slot),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else if (w_load1) begin
      r_state <= LOCKED;
    end else if (w_miss) begin
      r_state <= HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_sh_c <= '0;
    end else if (w_load1) begin
      r_sh_a <= in_data;
    end else if (w_adv) begin
      case (w_slot)
        SLOT_B:  r_sh_b <= in_data;
        SLOT_C:  r_sh_c <= in_data;
        default: ;
      endcase
    end
  end

  // Slot 3 bypasses the shadow so all four outputs flip on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_a <= '0;
      r_out_b <= '0;
      r_out_c <= '0;
      r_out_d <= '0;
    end else if (w_frame_done) begin
      r_out_a <= r_sh_a;
      r_out_b <= r_sh_b;
      r_out_c <= r_sh_c;
      r_out_d <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      r_sync_err    <= w_early | w_miss;
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (err_clr) begin
      r_err_cnt <= 8'd0;
    end else if (r_sync_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_c       = r_out_c;
  assign out_d       = r_out_d;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = w_lk;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: vector table, directed corner sequences and a frame-level reference model.
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sync = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         frame_valid, sync_err, locked;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]   err_count;
  logic         err_clr = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .in_data     (in_data),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
`ifdef TDM_DEMUX_ERR_CNT_EN
    .err_count   (err_count),
    .err_clr     (err_clr),
`endif
    .locked      (locked)
  );

  // Frame-level model: a list of collected channel values plus a lock flag.
  bit           m_locked;
  int           m_q[$];
  logic [W-1:0] m_out[4];
  bit           m_fv, m_err;

  function automatic void model_reset();
    m_locked = 0;
    m_q.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_fv = 0;
    m_err = 0;
  endfunction

  function automatic void model_step(bit v, bit s, int d);
    m_fv = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1;
        m_q.delete();
        m_q.push_back(d);
      end
    end else if (s) begin
      if (m_q.size() != 0) m_err = 1;
      m_q.delete();
      m_q.push_back(d);
    end else if (m_q.size() == 0) begin
      m_err = 1;
      m_locked = 0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == 4) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_q[i][W-1:0];
        m_fv = 1;
        m_q.delete();
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " out_a"}, 32'(out_a), 32'(m_out[0]));
    chk({tag, " out_b"}, 32'(out_b), 32'(m_out[1]));
    chk({tag, " out_c"}, 32'(out_c), 32'(m_out[2]));
    chk({tag, " out_d"}, 32'(out_d), 32'(m_out[3]));
    chk({tag, " frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, " sync_err"}, 32'(sync_err), 32'(m_err));
    chk({tag, " locked"}, 32'(locked), 32'(m_locked));
  endtask

  // Called at posedge+1: drive, take the edge, then sample 1 ns later.
  task automatic step(input bit v, input bit s, input int d, input string tag);
    in_valid = v;
    in_sync  = s;
    in_data  = W'(d);
    @(posedge clk);
    model_step(v, s, d);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    in_valid = 0;
    in_sync  = 0;
    in_data  = '0;
    rst_n    = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_model("reset");
    rst_n = 1;
  endtask

  typedef struct {
    bit            v;
    bit            s;
    logic [W-1:0]  d;
    logic [4*W-1:0] outs;
    bit            fv;
    bit            err;
    bit            lk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, bit s, int d, int outs, bit fv, bit err, bit lk);
    vec_t e;
    e.v = v; e.s = s; e.d = W'(d); e.outs = (4*W)'(outs);
    e.fv = fv; e.err = err; e.lk = lk;
    tbl.push_back(e);
  endfunction

  initial begin
    // Clean frame, ignored idle sync, back-to-back frames, early sync, missing sync, relock.
    add(1, 1, 'hA, 'h0000, 0, 0, 1);
    add(1, 0, 'hB, 'h0000, 0, 0, 1);
    add(1, 0, 'hC, 'h0000, 0, 0, 1);
    add(1, 0, 'hD, 'hABCD, 1, 0, 1);
    add(0, 1, 'h5, 'hABCD, 0, 0, 1);
    add(1, 1, 'h1, 'hABCD, 0, 0, 1);
    add(1, 0, 'h2, 'hABCD, 0, 0, 1);
    add(1, 0, 'h3, 'hABCD, 0, 0, 1);
    add(1, 0, 'h4, 'h1234, 1, 0, 1);
    add(1, 1, 'h5, 'h1234, 0, 0, 1);
    add(1, 0, 'h6, 'h1234, 0, 0, 1);
    add(1, 1, 'h7, 'h1234, 0, 1, 1);
    add(1, 0, 'h8, 'h1234, 0, 0, 1);
    add(1, 0, 'h9, 'h1234, 0, 0, 1);
    add(1, 0, 'hA, 'h789A, 1, 0, 1);
    add(1, 0, 'hF, 'h789A, 0, 1, 0);
    add(1, 0, 'h3, 'h789A, 0, 0, 0);
    add(1, 1, 'hE, 'h789A, 0, 0, 1);

    #1;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_sync  = tbl[i].s;
      in_data  = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d outs", i), 32'({out_a, out_b, out_c, out_d}), 32'(tbl[i].outs));
      chk($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(tbl[i].fv));
      chk($sformatf("vec%0d sync_err", i), 32'(sync_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].lk));
    end

    // Gapped frame with sync asserted on idle cycles.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      step(1, b == 0, 'hA + b, "gap beat");
      for (int g = 0; g < 3; g++) step(0, 1, 'h5, "gap idle");
    end
    chk("gap outs", 32'({out_a, out_b, out_c, out_d}), 32'h0000ABCD);

    // Asynchronous reset in the middle of a frame.
    step(1, 1, 'h3, "mid beat");
    step(1, 0, 'h4, "mid beat");
    #2;
    rst_n = 0;
    #1;
    chk("async rst outs", 32'({out_a, out_b, out_c, out_d}), 32'h0);
    chk("async rst locked", 32'(locked), 32'h0);
    chk("async rst frame_valid", 32'(frame_valid), 32'h0);
    model_reset();
    in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 'h5 + i, "post rst discard");
    step(1, 1, 'h1, "post rst frame");
    step(1, 0, 'h2, "post rst frame");
    step(1, 0, 'h3, "post rst frame");
    step(1, 0, 'h4, "post rst frame");

    // Random traffic; sync biased toward frame boundaries so frames complete.
    for (int i = 0; i < 2000; i++) begin
      bit v, s;
      v = ($urandom % 4) != 0;
      if (m_locked && m_q.size() == 0) s = ($urandom % 10) != 0;
      else s = ($urandom % 12) == 0;
      step(v, s, $urandom % (1 << W), "rand");
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    do_reset();
    #1;
    chk("err_count reset", 32'(err_count), 32'h0);
    step(1, 1, 0, "cnt lock");
    for (int i = 0; i < 300; i++) step(1, 1, i, "cnt early");
    step(0, 0, 0, "cnt idle");
    step(0, 0, 0, "cnt idle");
    chk("err_count saturate", 32'(err_count), 32'd255);
    step(1, 1, 1, "cnt early");
    err_clr = 1;
    step(0, 0, 0, "cnt clr");
    err_clr = 0;
    chk("err_count clear wins", 32'(err_count), 32'd0);
    step(1, 1, 2, "cnt early");
    step(0, 0, 0, "cnt idle");
    chk("err_count incr", 32'(err_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
